// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory responder: register window
// addresses and the host-port state encoding.
package dm_pkg;

  localparam logic [7:0] DM_MMIO_BASE = 8'hF0;
  localparam logic [7:0] DM_CNT_LO    = 8'hF0;
  localparam logic [7:0] DM_CNT_HI    = 8'hF1;
  localparam logic [7:0] DM_LED       = 8'hF2;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ACCESS,
    HS_ACK
  } hs_state_t;

endpackage

// File: rtl/dm_mmio_regs.sv
// Register window: free-running 16-bit cycle counter and LED register, with one
// arbitrated write port and two independent combinational read ports (CPU, host).
module dm_mmio_regs
  import dm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] led
);

  localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'(DM_CNT_LO);
  localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'(DM_CNT_HI);
  localparam logic [ADDR_W-1:0] A_LED    = ADDR_W'(DM_LED);

  logic [15:0]       cnt_reg;
  logic [DATA_W-1:0] led_reg;

  // A clear-write takes priority over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (wr_en && wr_addr == A_CNT_LO) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_reg <= '0;
    end else if (wr_en && wr_addr == A_LED) begin
      led_reg <= wr_data;
    end
  end

  assign led = led_reg;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = cpu_addr;
  assign rd_addr[1] = host_addr;
  assign cpu_rdata  = rd_data[0];
  assign host_rdata = rd_data[1];

  // Unmapped window addresses read as zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = '0;
        if (rd_addr[gi] == A_CNT_LO) begin
          rd_data[gi] = DATA_W'(cnt_reg[7:0]);
        end else if (rd_addr[gi] == A_CNT_HI) begin
          rd_data[gi] = DATA_W'(cnt_reg[15:8]);
        end else if (rd_addr[gi] == A_LED) begin
          rd_data[gi] = led_reg;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dm_responder.sv
// CPU data-memory responder: RAM below MMIO_BASE, register window above it, and a
// req/ack host port that only proceeds in cycles where the CPU is not writing.
module dm_responder
  import dm_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DM_MMIO_BASE)
) (
  input  logic              main_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_DM,
  input  logic [DATA_W-1:0] data_out_DM,
  input  logic              OUT_MW,
  output logic [DATA_W-1:0] data_in_DM,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] led_out
);

  localparam int RAM_DEPTH = int'(MMIO_BASE);

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  hs_state_t state_reg, state_next;
  logic      host_go;

  always_comb begin
    state_next = state_reg;
    host_go    = 1'b0;
    case (state_reg)
      HS_IDLE: begin
        if (host_req) state_next = HS_ACCESS;
      end
      HS_ACCESS: begin
        // Any CPU write cycle defers the host, read or write alike.
        if (!OUT_MW && rst) begin
          host_go    = 1'b1;
          state_next = HS_ACK;
        end
      end
      HS_ACK: begin
        state_next = HS_IDLE;
      end
      default: begin
        state_next = HS_IDLE;
      end
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (!rst) begin
      state_reg <= HS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign host_ack = (state_reg == HS_ACK);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_we;
  logic              mmio_we;

  assign wr_en   = OUT_MW | (host_go & host_we);
  assign wr_addr = OUT_MW ? address_DM : host_addr;
  assign wr_data = OUT_MW ? data_out_DM : host_wdata;
  assign ram_we  = wr_en && (wr_addr < MMIO_BASE);
  assign mmio_we = wr_en && (wr_addr >= MMIO_BASE);

  // RAM contents survive reset.
  always_ff @(posedge main_clk) begin
    if (ram_we) begin
      ram[wr_addr] <= wr_data;
    end
  end

  logic [DATA_W-1:0] mmio_cpu_rdata;
  logic [DATA_W-1:0] mmio_host_rdata;

  dm_mmio_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mmio (
    .clk        (main_clk),
    .rst        (rst),
    .wr_en      (mmio_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_addr   (address_DM),
    .cpu_rdata  (mmio_cpu_rdata),
    .host_addr  (host_addr),
    .host_rdata (mmio_host_rdata),
    .led        (led_out)
  );

  assign data_in_DM = (address_DM < MMIO_BASE) ? ram[address_DM] : mmio_cpu_rdata;

  logic [DATA_W-1:0] host_rdata_reg;

  always_ff @(posedge main_clk) begin
    if (!rst) begin
      host_rdata_reg <= '0;
    end else if (host_go && !host_we) begin
      host_rdata_reg <= (host_addr < MMIO_BASE) ? ram[host_addr] : mmio_host_rdata;
    end
  end

  assign host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: CPU/host accesses, deferral, counter wrap and
// reset behaviour, each checked against hand-computed values.
module tb_dm_responder;

  logic       main_clk;
  logic       rst;
  logic [7:0] address_DM;
  logic [7:0] data_out_DM;
  logic       OUT_MW;
  logic [7:0] data_in_DM;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [7:0] led_out;

  int vectors;
  int miscompares;

  dm_responder #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MMIO_BASE (8'hF0)
  ) dut (
    .main_clk    (main_clk),
    .rst         (rst),
    .address_DM  (address_DM),
    .data_out_DM (data_out_DM),
    .OUT_MW      (OUT_MW),
    .data_in_DM  (data_in_DM),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .led_out     (led_out)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    address_DM = addr;
    #1;
    check(tag, data_in_DM, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    address_DM  = 8'h00;
    data_out_DM = 8'h00;
    OUT_MW      = 1'b0;
    host_req    = 1'b0;
    host_we     = 1'b0;
    host_addr   = 8'h00;
    host_wdata  = 8'h00;

    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_led", led_out, 8'h00);
    check("rst_ack", {7'd0, host_ack}, 8'h00);
    check("rst_hrdata", host_rdata, 8'h00);
    cpu_read("rd_f2", 8'hF2, 8'h00);
    cpu_read("rd_f3", 8'hF3, 8'h00);
    cpu_read("rd_ff", 8'hFF, 8'h00);

    // CPU write then read-back
    address_DM = 8'h10; data_out_DM = 8'h5A; OUT_MW = 1'b1;
    step();
    OUT_MW = 1'b0;
    #1;
    check("cpu_rd_10", data_in_DM, 8'h5A);

    // Host read, no conflict: ack two edges after req
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    step();
    check("hrd_ack_n", {7'd0, host_ack}, 8'h00);
    step();
    check("hrd_ack", {7'd0, host_ack}, 8'h01);
    check("hrd_data", host_rdata, 8'h5A);
    host_req = 1'b0;
    step();
    check("hrd_ack_drop", {7'd0, host_ack}, 8'h00);
    check("hrd_hold", host_rdata, 8'h5A);

    // Host LED write deferred by three CPU write cycles
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'hF2; host_wdata = 8'hC3;
    step();
    for (int i = 0; i < 3; i++) begin
      address_DM = 8'h20 + 8'(i); data_out_DM = 8'h11 + 8'(i); OUT_MW = 1'b1;
      step();
      check("defer_ack", {7'd0, host_ack}, 8'h00);
      check("defer_led", led_out, 8'h00);
    end
    OUT_MW = 1'b0;
    step();
    check("hwr_ack", {7'd0, host_ack}, 8'h01);
    check("hwr_led", led_out, 8'hC3);
    host_req = 1'b0;
    step();
    check("hwr_ack_drop", {7'd0, host_ack}, 8'h00);
    cpu_read("cpu_rd_21", 8'h21, 8'h12);

    // Counter clear and count-up
    address_DM = 8'hF0; data_out_DM = 8'h99; OUT_MW = 1'b1;
    step();
    OUT_MW = 1'b0;
    #1;
    check("cnt_0", data_in_DM, 8'h00);
    step();
    check("cnt_1", data_in_DM, 8'h01);
    step();
    check("cnt_2", data_in_DM, 8'h02);

    // Run to 0xFFFF, then observe the wrap
    repeat (16'hFFFD) @(posedge main_clk);
    #1;
    cpu_read("cnt_hi_ff", 8'hF1, 8'hFF);
    cpu_read("cnt_lo_ff", 8'hF0, 8'hFF);
    step();
    cpu_read("wrap_hi", 8'hF1, 8'h00);
    cpu_read("wrap_lo", 8'hF0, 8'h00);

    // Writes to read-only / unmapped addresses leave the counter running
    address_DM = 8'hF1; data_out_DM = 8'h77; OUT_MW = 1'b1;
    step();
    OUT_MW = 1'b0;
    cpu_read("f1_wr_cnt", 8'hF0, 8'h01);
    address_DM = 8'hF8; data_out_DM = 8'h55; OUT_MW = 1'b1;
    step();
    OUT_MW = 1'b0;
    cpu_read("f8_rd", 8'hF8, 8'h00);
    cpu_read("f8_wr_cnt", 8'hF0, 8'h02);

    // Reset while the host FSM sits in ACCESS
    address_DM = 8'h30; data_out_DM = 8'hA7; OUT_MW = 1'b1;
    step();
    OUT_MW = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    step();
    rst = 1'b0;
    step();
    host_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2_ack", {7'd0, host_ack}, 8'h00);
    check("rst2_hrdata", host_rdata, 8'h00);
    check("rst2_led", led_out, 8'h00);
    cpu_read("rst2_cnt", 8'hF0, 8'h00);
    step();
    check("rst2_noack", {7'd0, host_ack}, 8'h00);
    cpu_read("rst2_ram", 8'h30, 8'hA7);

    // Fresh request shows full IDLE->ACCESS->ACK latency
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    step();
    check("rereq_ack_n", {7'd0, host_ack}, 8'h00);
    step();
    check("rereq_ack", {7'd0, host_ack}, 8'h01);
    check("rereq_data", host_rdata, 8'hA7);
    host_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
